// File: rtl/moore_scan_pkg.sv
// Shared definitions for the moore_scan_display block.
//   STATE_W      : width of the state encoding
//   HEX_FONT     : active-low gfedcba font for hex digits 0-F
//   SEG_BLANK    : all segments off
//   hist_entry_t : one history slot (valid flag + state value)
//   seg_of()     : segment pattern for a history slot, blank when invalid
package moore_scan_pkg;

    localparam int STATE_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 is the rightmost entry: 0,1,2,...,F read right to left.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic               valid;
        logic [STATE_W-1:0] value;
    } hist_entry_t;

    function automatic logic [6:0] seg_of(input hist_entry_t e);
        return e.valid ? HEX_FONT[e.value] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/moore_scan_display_tick_gen.sv
// tick_gen: free-running counter 0..PERIOD-1 that raises a one-cycle pulse
// while the count sits at PERIOD-1. Restarts from 0 on reset.
//   clk   : system clock
//   reset : asynchronous, active-low
//   pulse : high for one cycle every PERIOD cycles
module tick_gen #(
    parameter int PERIOD = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pulse
);

    localparam int                CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse = (cnt_q == LAST);

endmodule

// File: rtl/moore_scan_display.sv
// moore_scan_display: table-driven Moore sequencer stepped by an internal
// tick (or by manual step pulses while held), with the last DIGITS states
// shown on a scanned active-low seven-segment display.
//   clk   : system clock
//   reset : asynchronous, active-low
//   in    : transition select (asynchronous pad, synchronised)
//   hold  : stop automatic stepping (asynchronous pad, synchronised)
//   step  : manual advance while held, rising edge (asynchronous pad)
//   state : current state
//   tick  : one-cycle pulse every DIV cycles
//   seg   : segments gfedcba, active-low
//   an    : digit enables, active-low, one digit at a time
// Build option: MOORE_SCAN_DEBOUNCE_EN adds a 16-cycle stability filter on
// the synchronised hold and step signals.
module moore_scan_display
    import moore_scan_pkg::*;
#(
    parameter int          N_STATES = 6,
    parameter logic [63:0] NEXT0    = 64'h0000_0000_0002_4321,
    parameter logic [63:0] NEXT1    = 64'h0000_0000_0045_1053,
    parameter int          DIV      = 25_000_000,
    parameter int          SCAN_DIV = 50_000,
    parameter int          DIGITS   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               hold,
    input  logic               step,
    output logic [STATE_W-1:0] state,
    output logic               tick,
    output logic [6:0]         seg,
    output logic [DIGITS-1:0]  an
);

    localparam int                  DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIG_W-1:0]    DIG_LAST = DIG_W'(DIGITS - 1);
    localparam int                  LIM_W    = STATE_W + 1;
    localparam logic [LIM_W-1:0]    N_LIMIT  = LIM_W'(N_STATES);

    logic [1:0]         in_sync_q, in_sync_d;
    logic [1:0]         hold_sync_q, hold_sync_d;
    logic [1:0]         step_sync_q, step_sync_d;
    logic               step_prev_q, step_prev_d;
    logic [DIG_W-1:0]   dig_q, dig_d;
    hist_entry_t        hist_q [DIGITS];
    hist_entry_t        hist_d [DIGITS];

    logic               in_s, hold_s, step_s;
    logic               hold_use, step_use;
    logic               step_rise, adv, scan_pulse;
    logic [STATE_W-1:0] cur, entry, next_state;

    assign in_s   = in_sync_q[1];
    assign hold_s = hold_sync_q[1];
    assign step_s = step_sync_q[1];

`ifdef MOORE_SCAN_DEBOUNCE_EN
    // Filtered value follows its input only after 16 consecutive cycles of
    // disagreement; any cycle of agreement restarts the count.
    logic       hold_filt_q, hold_filt_d;
    logic       step_filt_q, step_filt_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] step_cnt_q, step_cnt_d;

    always_comb begin
        hold_filt_d = hold_filt_q;
        hold_cnt_d  = '0;
        if (hold_s != hold_filt_q) begin
            if (hold_cnt_q == 4'd15) begin
                hold_filt_d = hold_s;
            end else begin
                hold_cnt_d = hold_cnt_q + 4'd1;
            end
        end
        step_filt_d = step_filt_q;
        step_cnt_d  = '0;
        if (step_s != step_filt_q) begin
            if (step_cnt_q == 4'd15) begin
                step_filt_d = step_s;
            end else begin
                step_cnt_d = step_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_filt_q <= 1'b0;
            step_filt_q <= 1'b0;
            hold_cnt_q  <= '0;
            step_cnt_q  <= '0;
        end else begin
            hold_filt_q <= hold_filt_d;
            step_filt_q <= step_filt_d;
            hold_cnt_q  <= hold_cnt_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign hold_use = hold_filt_q;
    assign step_use = step_filt_q;
`else
    assign hold_use = hold_s;
    assign step_use = step_s;
`endif

    tick_gen #(.PERIOD(DIV)) u_state_tick (
        .clk   (clk),
        .reset (reset),
        .pulse (tick)
    );

    tick_gen #(.PERIOD(SCAN_DIV)) u_scan_tick (
        .clk   (clk),
        .reset (reset),
        .pulse (scan_pulse)
    );

    // Edge detect runs on the post-filter signal so a long press counts once.
    assign step_rise = step_use & ~step_prev_q;
    assign adv       = (tick & ~hold_use) | (hold_use & step_rise);

    always_comb begin
        cur        = hist_q[0].value;
        entry      = in_s ? NEXT1[{cur, 2'b00} +: STATE_W]
                          : NEXT0[{cur, 2'b00} +: STATE_W];
        next_state = entry;
        // Out-of-range current state or table entry both fall back to 0.
        if (({1'b0, cur} >= N_LIMIT) || ({1'b0, entry} >= N_LIMIT)) begin
            next_state = '0;
        end
    end

    always_comb begin
        in_sync_d   = {in_sync_q[0], in};
        hold_sync_d = {hold_sync_q[0], hold};
        step_sync_d = {step_sync_q[0], step};
        step_prev_d = step_use;

        dig_d = dig_q;
        if (scan_pulse) begin
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        end

        hist_d = hist_q;
        if (adv) begin
            for (int i = DIGITS - 1; i > 0; i--) begin
                hist_d[i] = hist_q[i-1];
            end
            hist_d[0].valid = 1'b1;
            hist_d[0].value = next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_sync_q   <= '0;
            hold_sync_q <= '0;
            step_sync_q <= '0;
            step_prev_q <= 1'b0;
            dig_q       <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                hist_q[i] <= '0;
            end
            hist_q[0].valid <= 1'b1;
        end else begin
            in_sync_q   <= in_sync_d;
            hold_sync_q <= hold_sync_d;
            step_sync_q <= step_sync_d;
            step_prev_q <= step_prev_d;
            dig_q       <= dig_d;
            hist_q      <= hist_d;
        end
    end

    // hist[0] doubles as the state register.
    assign state = hist_q[0].value;

    always_comb begin
        an        = '1;
        an[dig_q] = 1'b0;
        seg       = seg_of(hist_q[dig_q]);
    end

endmodule

// File: tb/tb_moore_scan_display.sv
module tb_moore_scan_display;

    localparam int DIV      = 4;
    localparam int SCAN_DIV = 3;
    localparam int DIGITS   = 4;

    localparam logic [63:0] A_N0 = 64'h0000_0000_0002_4321;
    localparam logic [63:0] A_N1 = 64'h0000_0000_0045_1053;
    localparam logic [63:0] B_N0 = 64'h0000_0000_0000_0921;
    localparam logic [63:0] B_N1 = 64'h0000_0000_0045_1053;
    localparam int          A_NS = 6;
    localparam int          B_NS = 4;

`ifdef MOORE_SCAN_DEBOUNCE_EN
    localparam int FLT = 16;
`else
    localparam int FLT = 0;
`endif
    localparam int STEP_LAT  = 3 + FLT;
    localparam int HLAT      = 2 + FLT;
    localparam int STEP_HIGH = STEP_LAT + 2;

    logic clk = 1'b0;
    logic reset;
    logic in_pad, hold_pad, step_pad;
    logic [3:0] a_state, b_state;
    logic       a_tick, b_tick;
    logic [6:0] a_seg, b_seg;
    logic [3:0] a_an, b_an;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    moore_scan_display #(
        .N_STATES(A_NS), .NEXT0(A_N0), .NEXT1(A_N1),
        .DIV(DIV), .SCAN_DIV(SCAN_DIV), .DIGITS(DIGITS)
    ) dut_a (
        .clk(clk), .reset(reset), .in(in_pad), .hold(hold_pad), .step(step_pad),
        .state(a_state), .tick(a_tick), .seg(a_seg), .an(a_an)
    );

    moore_scan_display #(
        .N_STATES(B_NS), .NEXT0(B_N0), .NEXT1(B_N1),
        .DIV(DIV), .SCAN_DIV(SCAN_DIV), .DIGITS(DIGITS)
    ) dut_b (
        .clk(clk), .reset(reset), .in(in_pad), .hold(hold_pad), .step(step_pad),
        .state(b_state), .tick(b_tick), .seg(b_seg), .an(b_an)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [6:0] font(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // Cycle c is the interval after the c-th rising edge following reset
    // release. Pads captured at edge k are stored at index k; a synchronised
    // pad seen during cycle c is the pad captured at edge c-1.
    int m_cyc;
    bit pin [64];
    bit phd [64];
    bit pst [64];
    bit eh  [64];
    bit es  [64];
    int m_state [2];
    int m_val   [2][4];
    bit m_vld   [2][4];

    function automatic int ix(input int k);
        return k & 63;
    endfunction

    function automatic int nxt(input int inst, input int s, input bit inb);
        logic [63:0] t;
        int ns, e;
        ns = (inst == 1) ? B_NS : A_NS;
        if (inst == 1) t = inb ? B_N1 : B_N0;
        else           t = inb ? A_N1 : A_N0;
        e = int'((t >> (4 * s)) & 64'hF);
        if (s >= ns || e >= ns) return 0;
        return e;
    endfunction

    function automatic bit raw_of(input bit is_step, input int c);
        return is_step ? pst[ix(c - 1)] : phd[ix(c - 1)];
    endfunction

    // Effective hold/step in cycle c: the raw synchronised value, or with the
    // filter, the value held for the previous 16 cycles (else unchanged).
    function automatic bit eff(input bit is_step, input int c, input bit prev);
        bit v;
        if (FLT == 0) return raw_of(is_step, c);
        v = raw_of(is_step, c - 1);
        for (int k = c - FLT; k < c; k++) begin
            if (raw_of(is_step, k) != v) return prev;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        for (int k = 0; k < 64; k++) begin
            pin[k] = 0; phd[k] = 0; pst[k] = 0; eh[k] = 0; es[k] = 0;
        end
        for (int u = 0; u < 2; u++) begin
            m_state[u] = 0;
            for (int d = 0; d < 4; d++) begin
                m_val[u][d] = 0;
                m_vld[u][d] = (d == 0);
            end
        end
    endtask

    task automatic model_step();
        int n, c, ns;
        bit hp, rise, inp, adv;
        n = m_cyc + 1;
        c = m_cyc;
        pin[ix(n)] = in_pad;
        phd[ix(n)] = hold_pad;
        pst[ix(n)] = step_pad;
        hp   = eh[ix(c)];
        rise = es[ix(c)] && !es[ix(c - 1)];
        inp  = pin[ix(c - 1)];
        adv  = (((c % DIV) == DIV - 1) && !hp) || (hp && rise);
        if (adv) begin
            for (int u = 0; u < 2; u++) begin
                ns = nxt(u, m_state[u], inp);
                for (int d = 3; d > 0; d--) begin
                    m_val[u][d] = m_val[u][d-1];
                    m_vld[u][d] = m_vld[u][d-1];
                end
                m_val[u][0] = ns;
                m_vld[u][0] = 1;
                m_state[u]  = ns;
            end
        end
        m_cyc = n;
        eh[ix(n)] = eff(1'b0, n, eh[ix(n - 1)]);
        es[ix(n)] = eff(1'b1, n, es[ix(n - 1)]);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        int d;
        logic [3:0] e_an;
        d    = (m_cyc / SCAN_DIV) % DIGITS;
        e_an = ~(4'b0001 << d);
        check("a_state", a_state, m_state[0]);
        check("b_state", b_state, m_state[1]);
        check("a_tick", a_tick, int'((m_cyc % DIV) == DIV - 1));
        check("b_tick", b_tick, int'((m_cyc % DIV) == DIV - 1));
        check("a_an", a_an, e_an);
        check("b_an", b_an, e_an);
        check("a_seg", a_seg, m_vld[0][d] ? font(m_val[0][d]) : 7'h7F);
        check("b_seg", b_seg, m_vld[1][d] ? font(m_val[1][d]) : 7'h7F);
    end

    // ---------------- directed stimulus ----------------
    task automatic to_cyc(input int t);
        int b = 0;
        while (m_cyc < t && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (m_cyc < t) check("to_cyc_timeout", m_cyc, t);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
    endtask

    int a_walk  [7] = '{1, 2, 3, 4, 2, 3, 4};
    int b_walk  [7] = '{1, 2, 0, 1, 2, 0, 1};
    int a_walk1 [7] = '{3, 1, 5, 4, 5, 4, 5};
    int step_seq[3] = '{4, 5, 4};

    initial begin
        int n, t0, chg, prev;
        logic [6:0] cap [4];
        reset = 1'b0; in_pad = 1'b0; hold_pad = 1'b0; step_pad = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_state", a_state, 0);
        check("rst_seg", a_seg, 7'h40);
        check("rst_an", a_an, 4'b1110);
        check("rst_tick", a_tick, 0);
        @(posedge clk); #2 reset = 1'b1;

        // Walk with in=0; instance B has an out-of-range entry for state 2.
        to_cyc(3);
        check("blank_dig1_seg", a_seg, 7'h7F);
        check("blank_dig1_an", a_an, 4'b1101);
        for (int k = 1; k <= 7; k++) begin
            to_cyc(4 * k);
            check("walk_in0_a", a_state, a_walk[k-1]);
            check("walk_in0_b", b_state, b_walk[k-1]);
        end

        // in=1 path; hold lands just after the 7th advance.
        in_pad = 1'b1;
        pulse_reset();
        for (int c = 1; c <= 28; c++) begin
            to_cyc(c);
            if (c == 28 - HLAT) hold_pad = 1'b1;
            if (c % 4 == 0) check("walk_in1_a", a_state, a_walk1[c/4-1]);
        end
        for (int d = 0; d < 4; d++) cap[d] = 7'h00;
        for (int c = 29; c <= 40; c++) begin
            to_cyc(c);
            case (a_an)
                4'b1110: cap[0] = a_seg;
                4'b1101: cap[1] = a_seg;
                4'b1011: cap[2] = a_seg;
                4'b0111: cap[3] = a_seg;
                default: ;
            endcase
        end
        check("hist_dig0", cap[0], 7'h12);
        check("hist_dig1", cap[1], 7'h19);
        check("hist_dig2", cap[2], 7'h12);
        check("hist_dig3", cap[3], 7'h19);
        check("held_state", a_state, 5);

        // Manual steps while held.
        for (int s = 0; s < 3; s++) begin
            t0 = m_cyc;
            step_pad = 1'b1;
            n = 0;
            while (a_state != step_seq[s] && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check("step_latency", n, STEP_LAT);
            check("step_state", a_state, step_seq[s]);
            to_cyc(t0 + STEP_HIGH);
            step_pad = 1'b0;
            to_cyc(t0 + STEP_HIGH + FLT + 6);
        end

        step_pad = 1'b1;
        chg = 0;
        prev = 4;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            if (i == 30) step_pad = 1'b0;
            if (a_state != prev) begin
                chg++;
                prev = a_state;
            end
        end
        check("long_step_advances", chg, 1);
        check("long_step_state", a_state, 5);

`ifdef MOORE_SCAN_DEBOUNCE_EN
        t0 = m_cyc;
        step_pad = 1'b1;
        to_cyc(t0 + 10);
        step_pad = 1'b0;
        to_cyc(t0 + 40);
        check("glitch_no_advance", a_state, 5);
`endif

        // Release hold so it drops exactly in a tick cycle.
        t0 = m_cyc + 1;
        while (((t0 + HLAT) % DIV) != DIV - 1) t0++;
        to_cyc(t0);
        hold_pad = 1'b0;
        to_cyc(t0 + HLAT + 2);
        check("hold_release_tick", a_state, 4);

        // Mid-operation reset in state 4 with the tick counter at 2.
        in_pad = 1'b0;
        pulse_reset();
        to_cyc(17);
        check("pre_reset_a", a_state, 4);
        check("pre_reset_b", b_state, 1);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        check("mid_rst_state", a_state, 0);
        check("mid_rst_tick", a_tick, 0);
        check("mid_rst_seg", a_seg, 7'h40);
        check("mid_rst_an", a_an, 4'b1110);
        @(posedge clk); #2 reset = 1'b1;
        n = 0;
        while (a_state != 1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_tick_after_reset", n, DIV);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
